qdma_stm_lpbk_pkt: RTL and testbench
====================================

// Module: qdma_stm_lpbk_pkt
// PURPOSE
//  Streaming H2C->C2H loopback: translates H2C header beats to C2H format and buffers beats in a
//  depth-parametrised FIFO. Adds store-and-forward (SF) packet mode, SOP/header protocol checking,
//  a tdest output and statistics counters. Sits between the H2C and C2H fabric stream ports in the example design.
// PARAMETERS
//  MAX_DATA_WIDTH  512  tdata width; must be >= $bits(h2c_stub_hdr_beat_t) and >= $bits(c2h_stub_hdr_beat_t)
//  TDEST_BITS      16   tdest width
//  FIFO_DEPTH      16   beats buffered; power of 2, >= 2
//  TCQ             0    clock-to-q delay for simulation
// PORTS
//  clk             in   1    clock
//  rst_n           in   1    asynchronous active-low reset
//  cfg_en          in   1    1 = accept input; 0 = in_axis_tready held 0 (output keeps draining)
//  cfg_sf_en       in   1    1 = store-and-forward, 0 = cut-through; applied only while the FIFO is empty
//  stat_clr        in   1    one-cycle pulse: clear all stat_* counters
//  in_axis_tdata   in   MAX_DATA_WIDTH  input data
//  in_axis_tvalid  in   1    input valid
//  in_axis_tdest   in   TDEST_BITS      input tdest
//  in_axis_tuser   in   1    1 = header beat
//  in_axis_tlast   in   1    last beat of packet
//  in_axis_tready  out  1    input ready
//  out_axis_tdata  out  MAX_DATA_WIDTH  output data (translated if header)
//  out_axis_tdest  out  TDEST_BITS      output tdest, copied from input unchanged
//  out_axis_tuser  out  1    header flag, copied unchanged
//  out_axis_tlast  out  1    last flag, copied unchanged
//  out_axis_tvalid out  1    output valid
//  out_axis_tready in   1    output ready
//  stat_pkt_cnt    out  32   output packets (tlast handshakes); wraps
//  stat_beat_cnt   out  32   output beats; wraps
//  stat_err_nohdr  out  16   accepted SOP beats with tuser=0; saturates at 16'hFFFF
//  stat_err_midhdr out  16   accepted non-SOP beats with tuser=1; saturates at 16'hFFFF
//  stat_sf_ovf     out  1    sticky: SF cut-through fallback has occurred; cleared by stat_clr
// BEHAVIOUR
//  Reset: FIFO empty, pkt_cnt=0, sop_q=1, sf_mode_q=0. All outputs 0, including out_axis_tvalid and
//   in_axis_tready. A reset asserted mid-packet discards buffered beats; no partial-packet state survives.
//  Translation (comb, input side, when in_axis_tuser=1): c2h = '0. Copy qid, flow_id, tdest, rsv3.
//   cmp.tmh.pkt_len = cdh_slot_0.tmh.pld_len; cmp.tmh.eot = cdh_slot_0.tmh.eot.
//   usr_int = 0; cmp_data_0 = 0. Upper tdata bits above the struct are 0.
//   When tuser=0, tdata is passed bit-exact.
//  Input handshake: in_axis_tready = cfg_en && !full. The ready decision ignores any same-cycle pop.
//   Accept = tvalid && tready.
//  Latency: a beat accepted in cycle N can be presented on out_axis_* in cycle N+1 (cut-through).
//  Output: AXIS rules apply. tdata/tdest/tuser/tlast hold stable while tvalid && !tready.
//   Pop = out_axis_tvalid && out_axis_tready.
//  pkt_cnt ($clog2(FIFO_DEPTH+1) bits): +1 on accepted tlast, -1 on popped tlast; both in the same cycle -> unchanged.
//  sf_mode_q: loads cfg_sf_en in any cycle where the FIFO is empty and no push occurs.
//  out_axis_tvalid = !empty && (!sf_mode_q || pkt_cnt!=0 || sf_rel_q).
//  SF deadlock rule: if sf_mode_q && full && pkt_cnt==0, then sf_rel_q<=1 and stat_sf_ovf<=1.
//   The packet then drains cut-through; sf_rel_q clears on the pop of its tlast.
//  SOP tracking: sop_q<=1 on accepted tlast; sop_q<=0 on accepted non-last beat.
//   Accept with sop_q && !tuser -> err_nohdr+1. Accept with !sop_q && tuser -> err_midhdr+1.
//   Erroneous beats are still forwarded; a mid-packet header beat is still translated.
//  Counters: stat_clr has priority over a same-cycle increment; the result is 0 after that edge.
//  Full/empty: pointers are $clog2(FIFO_DEPTH)+1 bits, with MSB as the wrap flag. Push on full or pop on empty never happens.
// STRUCTURE
//  Shared package qdma_stm_defines.svh: h2c_stub_hdr_beat_t and c2h_stub_hdr_beat_t (existing).
//   Add lpbk_beat_t {tdata,tuser,tdest,tlast} there.
//  Top: translation, SOP/error logic, SF gating, stats.
//  Sub-module qdma_stm_lpbk_pfifo: register-array FIFO with full/empty and pkt_cnt.
//   Ports: clk, rst_n, push, pop, din, dout, full, empty, pkt_cnt.
// TESTING
//  1. Cut-through, out_tready=1. Send hdr(qid=5, pld_len=64, eot=1) + 2 payload beats, last on beat 3.
//     -> 3 out beats, first at N+1; c2h pkt_len=64, eot=1, usr_int=0; payload bit-exact;
//     stat_pkt_cnt=1, stat_beat_cnt=3.
//  2. SF mode, FIFO_DEPTH=16, 4-beat packet with 2 idle cycles between beats.
//     -> out_axis_tvalid=0 until the cycle after the tlast accept, then 4 contiguous beats.
//  3. SF mode, 20-beat packet. -> FIFO fills with 16 beats, stat_sf_ovf=1, all 20 beats delivered in order;
//     the next 3-beat packet is held until its tlast (SF mode restored).
//  4. Backpressure: out_tready=0 for 20 cycles while streaming. -> in_tready=0 after 16 accepts;
//     output signals stable; no loss or duplication (check with a scoreboard).
//  5. Protocol: payload beat at SOP, then tuser=1 mid-packet. -> err_nohdr=1, err_midhdr=1, both beats forwarded.
//     stat_clr in the same cycle as a tlast pop -> all counters read 0.
//  6. Assert rst_n low mid-packet with 5 beats buffered. -> tvalid=0 immediately; after release, FIFO empty,
//     a new packet passes; cfg_en=0 -> in_tready=0.

Source files
------------

// File: rtl/qdma_stm_lpbk_pkt_pkg.sv
// Shared types for the H2C->C2H streaming loopback: stub header layouts, the buffered
// beat record and the header translation helper.
package qdma_stm_lpbk_pkt_pkg;

  localparam int unsigned LpbkDataW  = 512;
  localparam int unsigned LpbkTdestW = 16;

  typedef struct packed {
    logic [15:0] pld_len;
    logic        eot;
    logic [14:0] rsv;
  } h2c_tmh_t;

  typedef struct packed {
    h2c_tmh_t tmh;
  } h2c_cdh_slot_t;

  typedef struct packed {
    h2c_cdh_slot_t cdh_slot_0;
    logic [7:0]    rsv3;
    logic [15:0]   tdest;
    logic [7:0]    flow_id;
    logic [10:0]   qid;
  } h2c_stub_hdr_beat_t;

  typedef struct packed {
    logic [15:0] pkt_len;
    logic        eot;
    logic [14:0] rsv;
  } c2h_tmh_t;

  typedef struct packed {
    c2h_tmh_t tmh;
  } c2h_cmp_t;

  typedef struct packed {
    logic        usr_int;
    logic [63:0] cmp_data_0;
    c2h_cmp_t    cmp;
    logic [7:0]  rsv3;
    logic [15:0] tdest;
    logic [7:0]  flow_id;
    logic [10:0] qid;
  } c2h_stub_hdr_beat_t;

  typedef struct packed {
    logic [LpbkDataW-1:0]  tdata;
    logic                  tuser;
    logic [LpbkTdestW-1:0] tdest;
    logic                  tlast;
  } lpbk_beat_t;

  localparam int unsigned H2cHdrW = $bits(h2c_stub_hdr_beat_t);
  localparam int unsigned C2hHdrW = $bits(c2h_stub_hdr_beat_t);

  function automatic c2h_stub_hdr_beat_t h2c_to_c2h(h2c_stub_hdr_beat_t h);
    c2h_stub_hdr_beat_t c;
    c                 = '0;
    c.qid             = h.qid;
    c.flow_id         = h.flow_id;
    c.tdest           = h.tdest;
    c.rsv3            = h.rsv3;
    c.cmp.tmh.pkt_len = h.cdh_slot_0.tmh.pld_len;
    c.cmp.tmh.eot     = h.cdh_slot_0.tmh.eot;
    return c;
  endfunction

endpackage

// File: rtl/qdma_stm_lpbk_pkt_pfifo.sv
// Register-array beat FIFO with wrap-flag pointers and a count of complete packets held.
// Bit 0 of each entry is the tlast flag.
module qdma_stm_lpbk_pfifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  pkt_cnt
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0]     PtrOne = (AW + 1)'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [AW:0]      wptr_q, rptr_q;
  logic [CntW-1:0]  pkt_cnt_q;
  logic [Width-1:0] mem_q [Depth];

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout    = mem_q[rptr_q[AW-1:0]];
  assign pkt_cnt = pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      unique case ({push && din[0], pop && dout[0]})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + CntOne;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - CntOne;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/qdma_stm_lpbk_pkt.sv
// H2C->C2H streaming loopback: header translation, beat buffering with optional
// store-and-forward, SOP/header protocol checking and statistics.
module qdma_stm_lpbk_pkt
  import qdma_stm_lpbk_pkt_pkg::*;
#(
  parameter int MAX_DATA_WIDTH = 512,
  parameter int TDEST_BITS     = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int TCQ            = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_en,
  input  logic                      cfg_sf_en,
  input  logic                      stat_clr,
  input  logic [MAX_DATA_WIDTH-1:0] in_axis_tdata,
  input  logic                      in_axis_tvalid,
  input  logic [TDEST_BITS-1:0]     in_axis_tdest,
  input  logic                      in_axis_tuser,
  input  logic                      in_axis_tlast,
  output logic                      in_axis_tready,
  output logic [MAX_DATA_WIDTH-1:0] out_axis_tdata,
  output logic [TDEST_BITS-1:0]     out_axis_tdest,
  output logic                      out_axis_tuser,
  output logic                      out_axis_tlast,
  output logic                      out_axis_tvalid,
  input  logic                      out_axis_tready,
  output logic [31:0]               stat_pkt_cnt,
  output logic [31:0]               stat_beat_cnt,
  output logic [15:0]               stat_err_nohdr,
  output logic [15:0]               stat_err_midhdr,
  output logic                      stat_sf_ovf
);

  localparam int unsigned BeatW = MAX_DATA_WIDTH + TDEST_BITS + 2;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TCQ < 0 ||
      MAX_DATA_WIDTH < int'(H2cHdrW) || MAX_DATA_WIDTH < int'(C2hHdrW)) begin : g_bad_param
    $error("qdma_stm_lpbk_pkt: illegal parameter set");
  end

  h2c_stub_hdr_beat_t        hdr_in;
  c2h_stub_hdr_beat_t        hdr_out;
  logic [MAX_DATA_WIDTH-1:0] xl_tdata;
  logic [BeatW-1:0]          fifo_din, fifo_dout;
  logic                      fifo_full, fifo_empty;
  logic [CntW-1:0]           pkt_cnt;
  logic                      push, pop, sf_trip, err_nohdr, err_midhdr;

  // rdy_q keeps tready low through reset and the first cycle after release.
  logic rdy_q, sop_q, sf_mode_q, sf_rel_q, sf_ovf_q;
  logic [31:0] pkt_q, beat_q;
  logic [15:0] nohdr_q, midhdr_q;

  always_comb begin
    hdr_in   = h2c_stub_hdr_beat_t'(in_axis_tdata[H2cHdrW-1:0]);
    hdr_out  = h2c_to_c2h(hdr_in);
    xl_tdata = '0;
    xl_tdata[C2hHdrW-1:0] = hdr_out;
    if (!in_axis_tuser) xl_tdata = in_axis_tdata;
  end

  assign in_axis_tready  = rdy_q && cfg_en && !fifo_full;
  assign push            = in_axis_tvalid && in_axis_tready;
  assign fifo_din        = {xl_tdata, in_axis_tdest, in_axis_tuser, in_axis_tlast};
  assign {out_axis_tdata, out_axis_tdest, out_axis_tuser, out_axis_tlast} = fifo_dout;
  assign out_axis_tvalid = !fifo_empty && (!sf_mode_q || pkt_cnt != '0 || sf_rel_q);
  assign pop             = out_axis_tvalid && out_axis_tready;
  // A full FIFO with no complete packet can never release in SF mode; fall back to cut-through.
  assign sf_trip         = sf_mode_q && fifo_full && (pkt_cnt == '0);
  assign err_nohdr       = push && sop_q && !in_axis_tuser;
  assign err_midhdr      = push && !sop_q && in_axis_tuser;

  qdma_stm_lpbk_pfifo #(
    .Width (BeatW),
    .Depth (FIFO_DEPTH),
    .CntW  (CntW)
  ) u_pfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .pkt_cnt (pkt_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      sop_q     <= 1'b1;
      sf_mode_q <= 1'b0;
      sf_rel_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) sop_q <= in_axis_tlast;
      if (fifo_empty && !push) sf_mode_q <= cfg_sf_en;
      if (sf_trip) sf_rel_q <= 1'b1;
      else if (pop && out_axis_tlast) sf_rel_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q    <= '0;
      beat_q   <= '0;
      nohdr_q  <= '0;
      midhdr_q <= '0;
      sf_ovf_q <= 1'b0;
    end else if (stat_clr) begin
      pkt_q    <= '0;
      beat_q   <= '0;
      nohdr_q  <= '0;
      midhdr_q <= '0;
      sf_ovf_q <= 1'b0;
    end else begin
      if (pop) beat_q <= beat_q + 32'd1;
      if (pop && out_axis_tlast) pkt_q <= pkt_q + 32'd1;
      if (err_nohdr && nohdr_q != 16'hFFFF) nohdr_q <= nohdr_q + 16'd1;
      if (err_midhdr && midhdr_q != 16'hFFFF) midhdr_q <= midhdr_q + 16'd1;
      if (sf_trip) sf_ovf_q <= 1'b1;
    end
  end

  assign stat_pkt_cnt    = pkt_q;
  assign stat_beat_cnt   = beat_q;
  assign stat_err_nohdr  = nohdr_q;
  assign stat_err_midhdr = midhdr_q;
  assign stat_sf_ovf     = sf_ovf_q;

endmodule

// File: tb/tb_qdma_stm_lpbk_pkt.sv
// Directed bench for the loopback block with a beat scoreboard fed at input accept.
module tb_qdma_stm_lpbk_pkt;
  import qdma_stm_lpbk_pkt_pkg::*;

  localparam int DW = 512;
  localparam int TB = 16;

  logic          clk = 1'b0;
  logic          rst_n, cfg_en, cfg_sf_en, stat_clr;
  logic [DW-1:0] in_axis_tdata;
  logic          in_axis_tvalid, in_axis_tuser, in_axis_tlast, in_axis_tready;
  logic [TB-1:0] in_axis_tdest;
  logic [DW-1:0] out_axis_tdata;
  logic [TB-1:0] out_axis_tdest;
  logic          out_axis_tuser, out_axis_tlast, out_axis_tvalid, out_axis_tready;
  logic [31:0]   stat_pkt_cnt, stat_beat_cnt;
  logic [15:0]   stat_err_nohdr, stat_err_midhdr;
  logic          stat_sf_ovf;

  int vectors = 0;
  int miscompares = 0;
  lpbk_beat_t sb[$];

  always #5 clk = ~clk;

  qdma_stm_lpbk_pkt #(
    .MAX_DATA_WIDTH (DW),
    .TDEST_BITS     (TB),
    .FIFO_DEPTH     (16),
    .TCQ            (0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_en          (cfg_en),
    .cfg_sf_en       (cfg_sf_en),
    .stat_clr        (stat_clr),
    .in_axis_tdata   (in_axis_tdata),
    .in_axis_tvalid  (in_axis_tvalid),
    .in_axis_tdest   (in_axis_tdest),
    .in_axis_tuser   (in_axis_tuser),
    .in_axis_tlast   (in_axis_tlast),
    .in_axis_tready  (in_axis_tready),
    .out_axis_tdata  (out_axis_tdata),
    .out_axis_tdest  (out_axis_tdest),
    .out_axis_tuser  (out_axis_tuser),
    .out_axis_tlast  (out_axis_tlast),
    .out_axis_tvalid (out_axis_tvalid),
    .out_axis_tready (out_axis_tready),
    .stat_pkt_cnt    (stat_pkt_cnt),
    .stat_beat_cnt   (stat_beat_cnt),
    .stat_err_nohdr  (stat_err_nohdr),
    .stat_err_midhdr (stat_err_midhdr),
    .stat_sf_ovf     (stat_sf_ovf)
  );

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_hdr(logic [10:0] qid, logic [15:0] len, logic eot);
    logic [DW-1:0] r;
    h2c_stub_hdr_beat_t h;
    r = rnd();
    h = r[$bits(h2c_stub_hdr_beat_t)-1:0];
    h.qid = qid;
    h.cdh_slot_0.tmh.pld_len = len;
    h.cdh_slot_0.tmh.eot = eot;
    r[$bits(h2c_stub_hdr_beat_t)-1:0] = h;
    return r;
  endfunction

  // Expected output tdata, built from the translation rules.
  function automatic logic [DW-1:0] model_xl(logic [DW-1:0] d, logic user);
    h2c_stub_hdr_beat_t h;
    c2h_stub_hdr_beat_t c;
    logic [DW-1:0] r;
    if (!user) return d;
    h = d[$bits(h2c_stub_hdr_beat_t)-1:0];
    c = '0;
    c.qid = h.qid;
    c.flow_id = h.flow_id;
    c.tdest = h.tdest;
    c.rsv3 = h.rsv3;
    c.cmp.tmh.pkt_len = h.cdh_slot_0.tmh.pld_len;
    c.cmp.tmh.eot = h.cdh_slot_0.tmh.eot;
    r = '0;
    r[$bits(c2h_stub_hdr_beat_t)-1:0] = c;
    return r;
  endfunction

  // Handshakes sampled mid-cycle; they complete at the following rising edge.
  always @(negedge clk) begin
    lpbk_beat_t b;
    if (rst_n) begin
      if (in_axis_tvalid && in_axis_tready) begin
        b.tdata = model_xl(in_axis_tdata, in_axis_tuser);
        b.tuser = in_axis_tuser;
        b.tdest = in_axis_tdest;
        b.tlast = in_axis_tlast;
        sb.push_back(b);
      end
      if (out_axis_tvalid && out_axis_tready) begin
        vectors++;
        assert (sb.size() > 0) else begin
          miscompares++;
          $error("FAIL sb_underflow observed=unexpected_beat expected=none");
        end
        if (sb.size() > 0) begin
          b = sb.pop_front();
          chk("sb_tdata", out_axis_tdata, b.tdata);
          chk("sb_tdest", out_axis_tdest, b.tdest);
          chk("sb_tuser", out_axis_tuser, b.tuser);
          chk("sb_tlast", out_axis_tlast, b.tlast);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic [DW-1:0] d, logic u, logic l, logic [TB-1:0] dst);
    in_axis_tdata  = d;
    in_axis_tuser  = u;
    in_axis_tlast  = l;
    in_axis_tdest  = dst;
    in_axis_tvalid = 1'b1;
  endtask

  // Returns #1 after the accepting edge with tvalid dropped.
  task automatic send(logic [DW-1:0] d, logic u, logic l, logic [TB-1:0] dst);
    int n = 0;
    bit ok = 0;
    drive(d, u, l, dst);
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_axis_tready) ok = 1;
      @(posedge clk);
      #1;
      n++;
    end
    in_axis_tvalid = 1'b0;
    chk("send_accept", ok, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic chk_stats(string tag, int p, int b, int nh, int mh);
    chk({tag, "_pkt"}, stat_pkt_cnt, p);
    chk({tag, "_beat"}, stat_beat_cnt, b);
    chk({tag, "_nohdr"}, stat_err_nohdr, nh);
    chk({tag, "_midhdr"}, stat_err_midhdr, mh);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    c2h_stub_hdr_beat_t oc;
    logic [DW-1:0] beats4 [24];
    logic [DW-1:0] held;
    bit have, rdy;
    int acc;

    rst_n = 1'b0; cfg_en = 1'b1; cfg_sf_en = 1'b0; stat_clr = 1'b0; out_axis_tready = 1'b1;
    in_axis_tvalid = 1'b0; in_axis_tdata = '0; in_axis_tuser = 1'b0; in_axis_tlast = 1'b0;
    in_axis_tdest = '0;
    step(3);
    chk("rst_in_tready", in_axis_tready, 1'b0);
    chk("rst_out_tvalid", out_axis_tvalid, 1'b0);
    chk("rst_out_tdata", out_axis_tdata, '0);
    chk("rst_ovf", stat_sf_ovf, 1'b0);
    chk_stats("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(2);

    // 1: cut-through header + 2 payload beats
    send(mk_hdr(11'd5, 16'd64, 1'b1), 1'b1, 1'b0, 16'h00A1);
    chk("t1_latency_valid", out_axis_tvalid, 1'b1);
    oc = out_axis_tdata[$bits(c2h_stub_hdr_beat_t)-1:0];
    chk("t1_qid", oc.qid, 11'd5);
    chk("t1_pkt_len", oc.cmp.tmh.pkt_len, 16'd64);
    chk("t1_eot", oc.cmp.tmh.eot, 1'b1);
    chk("t1_usr_int", oc.usr_int, 1'b0);
    send(rnd(), 1'b0, 1'b0, 16'h00A1);
    send(rnd(), 1'b0, 1'b1, 16'h00A1);
    wait_drain();
    chk_stats("t1", 1, 3, 0, 0);

    // 2: store-and-forward, idle gaps between beats
    cfg_sf_en = 1'b1;
    step(2);
    for (int k = 0; k < 4; k++) begin
      send((k == 0) ? mk_hdr(11'd7, 16'd192, 1'b0) : rnd(), k == 0, k == 3, 16'h0B02);
      if (k < 3) begin
        chk("t2_held", out_axis_tvalid, 1'b0);
        for (int i = 0; i < 2; i++) begin
          step(1);
          chk("t2_held_idle", out_axis_tvalid, 1'b0);
        end
      end
    end
    chk("t2_release", out_axis_tvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_contig", out_axis_tvalid, 1'b1);
    end
    step(1);
    chk("t2_done", out_axis_tvalid, 1'b0);
    wait_drain();
    chk_stats("t2", 2, 7, 0, 0);

    // 3: SF packet larger than the FIFO falls back to cut-through
    for (int k = 0; k < 20; k++) begin
      send((k == 0) ? mk_hdr(11'd9, 16'd1280, 1'b1) : rnd(), k == 0, k == 19, 16'h0C03);
      if (k == 15) begin
        chk("t3_full_tready", in_axis_tready, 1'b0);
        chk("t3_full_held", out_axis_tvalid, 1'b0);
      end
    end
    wait_drain();
    chk("t3_ovf", stat_sf_ovf, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send((k == 0) ? mk_hdr(11'd10, 16'd128, 1'b1) : rnd(), k == 0, k == 2, 16'h0C04);
      chk("t3_sf_restored", out_axis_tvalid, k == 2);
    end
    wait_drain();
    chk_stats("t3", 4, 30, 0, 0);

    // 4: output backpressure for 20 cycles
    cfg_sf_en = 1'b0;
    step(2);
    for (int k = 0; k < 24; k++) beats4[k] = (k == 0) ? mk_hdr(11'd12, 16'd1536, 1'b1) : rnd();
    out_axis_tready = 1'b0;
    acc = 0;
    have = 0;
    drive(beats4[0], 1'b1, 1'b0, 16'h0D05);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_axis_tvalid) begin
        if (have) chk("t4_stable", out_axis_tdata, held);
        else begin
          held = out_axis_tdata;
          have = 1;
        end
      end
      rdy = in_axis_tready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc++;
        drive(beats4[acc], 1'b0, acc == 23, 16'h0D05);
      end
    end
    chk("t4_accepts", acc, 16);
    chk("t4_tready_low", in_axis_tready, 1'b0);
    chk("t4_valid_held", out_axis_tvalid, 1'b1);
    in_axis_tvalid = 1'b0;
    out_axis_tready = 1'b1;
    for (int k = acc; k < 24; k++) send(beats4[k], 1'b0, k == 23, 16'h0D05);
    wait_drain();
    chk_stats("t4", 5, 54, 0, 0);

    // 5: protocol errors and stat_clr priority
    stat_clr = 1'b1;
    step(1);
    stat_clr = 1'b0;
    chk_stats("t5_clr", 0, 0, 0, 0);
    chk("t5_clr_ovf", stat_sf_ovf, 1'b0);
    send(rnd(), 1'b0, 1'b0, 16'h0E06);
    send(mk_hdr(11'd14, 16'd32, 1'b1), 1'b1, 1'b1, 16'h0E06);
    wait_drain();
    chk_stats("t5_err", 1, 2, 1, 1);
    out_axis_tready = 1'b0;
    send(mk_hdr(11'd15, 16'd16, 1'b1), 1'b1, 1'b1, 16'h0E07);
    step(1);
    stat_clr = 1'b1;
    out_axis_tready = 1'b1;
    step(1);
    stat_clr = 1'b0;
    chk("t5_popped", sb.size(), 0);
    chk_stats("t5_clrpop", 0, 0, 0, 0);

    // 6: reset mid-packet, then recovery and cfg_en gating
    out_axis_tready = 1'b0;
    for (int k = 0; k < 5; k++)
      send((k == 0) ? mk_hdr(11'd16, 16'd640, 1'b0) : rnd(), k == 0, 1'b0, 16'h0F08);
    chk("t6_buffered_valid", out_axis_tvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_axis_tvalid, 1'b0);
    chk("t6_rst_tready", in_axis_tready, 1'b0);
    sb.delete();
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("t6_empty_after", out_axis_tvalid, 1'b0);
    chk_stats("t6_rst", 0, 0, 0, 0);
    out_axis_tready = 1'b1;
    send(mk_hdr(11'd17, 16'd64, 1'b1), 1'b1, 1'b0, 16'h0F09);
    send(rnd(), 1'b0, 1'b1, 16'h0F09);
    wait_drain();
    chk_stats("t6_new", 1, 2, 0, 0);
    cfg_en = 1'b0;
    #1;
    chk("t6_cfg_en_off", in_axis_tready, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
